// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the issuer, its interface and benches.
// XLEN sets the datapath width; SHW is the matching shift-count width.
package core_config_pkg;
   parameter int XLEN = 32;
   localparam int SHW = $clog2(XLEN);
endpackage

// File: rtl/alu_shift_issuer_if.sv
// Request, shift-unit and result signals of the ALU shift issuer.
// slave is the issuer view; master is the upstream/shifter/consumer view.
interface alu_shift_issuer_if;
   import core_config_pkg::*;

   logic            req_valid;
   logic            req_ready;
   logic [XLEN-1:0] req_data;
   logic [SHW-1:0]  req_amount;
   logic            req_left;
   logic            req_arith;
   logic [4:0]      req_tag;
   logic            flush;

   logic            sh_start;
   logic [XLEN-1:0] sh_data_in;
   logic [SHW-1:0]  sh_shift_amount;
   logic            sh_shift_left;
   logic            sh_arithmetic;
   logic [XLEN-1:0] sh_data_out;
   logic            sh_done;

   logic            res_valid;
   logic            res_ready;
   logic [XLEN-1:0] res_data;
   logic [4:0]      res_tag;
   logic            res_err;
   logic            busy;

   modport slave (
      input  req_valid, req_data, req_amount, req_left,
      input  req_arith, req_tag, flush,
      input  sh_data_out, sh_done, res_ready,
      output req_ready, sh_start, sh_data_in, sh_shift_amount,
      output sh_shift_left, sh_arithmetic,
      output res_valid, res_data, res_tag, res_err, busy
   );

   modport master (
      output req_valid, req_data, req_amount, req_left,
      output req_arith, req_tag, flush,
      output sh_data_out, sh_done, res_ready,
      input  req_ready, sh_start, sh_data_in, sh_shift_amount,
      input  sh_shift_left, sh_arithmetic,
      input  res_valid, res_data, res_tag, res_err, busy
   );
endinterface

// File: rtl/alu_shift_issuer.sv
// Issues one shift to an external shift unit and returns its result.
// Define ALU_ISSUER_TIMEOUT_EN to bound WAIT/DRAIN by TIMEOUT_CYCLES.
module alu_shift_issuer
`ifdef ALU_ISSUER_TIMEOUT_EN
   #(parameter int unsigned TIMEOUT_CYCLES = 64)
`endif
   (
   input  logic              clk,
   input  logic              rst_n,
   alu_shift_issuer_if.slave bus
);
   import core_config_pkg::*;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_DRAIN
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic            r_rdy;
   logic [XLEN-1:0] r_data;
   logic [SHW-1:0]  r_amt;
   logic            r_left;
   logic            r_arith;
   logic [4:0]      r_tag;
   logic [XLEN-1:0] r_res;
   logic            w_ready;
   logic            w_accept;
   logic            w_tmo;

   // r_rdy keeps req_ready low until the first clock after reset.
   assign w_ready  = (r_state == S_IDLE) && r_rdy && !bus.flush;
   assign w_accept = w_ready && bus.req_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_next = S_ISSUE;
         S_ISSUE: w_next = bus.flush ? S_DRAIN : S_WAIT;
         S_WAIT: begin
            if (bus.flush)
               w_next = bus.sh_done ? S_IDLE : S_DRAIN;
            else if (bus.sh_done || w_tmo)
               w_next = S_RESP;
         end
         S_RESP:  if (bus.flush || bus.res_ready) w_next = S_IDLE;
         S_DRAIN: if (bus.sh_done || w_tmo) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready       = w_ready;
      bus.busy            = (r_state != S_IDLE);
      bus.sh_start        = (r_state == S_ISSUE);
      bus.sh_data_in      = r_data;
      bus.sh_shift_amount = r_amt;
      bus.sh_shift_left   = r_left;
      bus.sh_arithmetic   = r_arith;
      bus.res_valid       = (r_state == S_RESP);
      bus.res_data        = r_res;
      bus.res_tag         = r_tag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rdy   <= 1'b0;
         r_data  <= '0;
         r_amt   <= '0;
         r_left  <= 1'b0;
         r_arith <= 1'b0;
         r_tag   <= '0;
         r_res   <= '0;
      end else begin
         r_rdy <= 1'b1;
         if (w_accept) begin
            r_data  <= bus.req_data;
            r_amt   <= bus.req_amount;
            r_left  <= bus.req_left;
            r_arith <= bus.req_arith;
            r_tag   <= bus.req_tag;
         end
         if (r_state == S_WAIT && !bus.flush) begin
            if (bus.sh_done)  r_res <= bus.sh_data_out;
            else if (w_tmo)   r_res <= '0;
         end
      end
   end

`ifdef ALU_ISSUER_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_cnt;
   logic          r_err;

   // Counter reads 0 in the first WAIT cycle, so RESP lands exactly
   // TIMEOUT_CYCLES after WAIT entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (r_state == S_ISSUE)
         r_cnt <= '0;
      else if (r_state == S_WAIT || r_state == S_DRAIN)
         r_cnt <= r_cnt + 1'b1;
   end

   assign w_tmo = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_err <= 1'b0;
      else if (r_state == S_WAIT && !bus.flush) begin
         if (bus.sh_done)  r_err <= 1'b0;
         else if (w_tmo)   r_err <= 1'b1;
      end
   end

   assign bus.res_err = r_err;
`else
   assign w_tmo       = 1'b0;
   assign bus.res_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_shift_issuer.sv
// Directed bench for alu_shift_issuer with a small shift-unit model.
// Timeout scenario runs only when ALU_ISSUER_TIMEOUT_EN is defined.
module tb_alu_shift_issuer;
   import core_config_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   int   lat;
   bit   stall;
   int   mcnt;
   logic [XLEN-1:0] m_d;
   logic [SHW-1:0]  m_a;
   logic            m_l;
   logic            m_ar;

   alu_shift_issuer_if bus();

   alu_shift_issuer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [XLEN-1:0] shf(
      input logic [XLEN-1:0] d, input logic [SHW-1:0] a,
      input logic l, input logic ar);
      if (l)       return d << a;
      else if (ar) return XLEN'($signed(d) >>> a);
      else         return d >> a;
   endfunction

   // Shift unit: done is a level that rises lat cycles after sh_start
   // and stays high until the next sh_start.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sh_done     <= 1'b0;
         bus.sh_data_out <= '0;
         mcnt            <= 0;
      end else if (bus.sh_start) begin
         bus.sh_done <= 1'b0;
         mcnt        <= lat - 1;
         m_d         <= bus.sh_data_in;
         m_a         <= bus.sh_shift_amount;
         m_l         <= bus.sh_shift_left;
         m_ar        <= bus.sh_arithmetic;
      end else if (mcnt == 1) begin
         if (!stall) begin
            bus.sh_done     <= 1'b1;
            bus.sh_data_out <= shf(m_d, m_a, m_l, m_ar);
         end
         mcnt <= 0;
      end else if (mcnt > 1) begin
         mcnt <= mcnt - 1;
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic send(input logic [XLEN-1:0] d, input logic [SHW-1:0] a,
                       input logic l, input logic ar, input logic [4:0] t);
      bus.req_valid  = 1'b1;
      bus.req_data   = d;
      bus.req_amount = a;
      bus.req_left   = l;
      bus.req_arith  = ar;
      bus.req_tag    = t;
      step();
      bus.req_valid  = 1'b0;
   endtask

   task automatic wait_res(input int budget, output int n);
      n = 0;
      while (bus.res_valid !== 1'b1 && n < budget) begin
         step();
         n++;
      end
      if (bus.res_valid !== 1'b1) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_res: res_valid=%b after %0d cycles, required 1",
                  bus.res_valid, budget);
      end
   endtask

   task automatic test_reset();
      step();
      step();
      n_vec++;
      if (bus.req_ready !== 1'b0 || bus.busy !== 1'b0 ||
          bus.sh_start !== 1'b0 || bus.res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctl: rdy=%b busy=%b start=%b rv=%b, required 0000",
                  bus.req_ready, bus.busy, bus.sh_start, bus.res_valid);
      end
      n_vec++;
      if (bus.sh_data_in !== '0 || bus.sh_shift_amount !== '0 ||
          bus.sh_shift_left !== 1'b0 || bus.sh_arithmetic !== 1'b0 ||
          bus.res_data !== '0 || bus.res_tag !== '0 || bus.res_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_data: sh_in=%h rd=%h tag=%h err=%b, required zeros",
                  bus.sh_data_in, bus.res_data, bus.res_tag, bus.res_err);
      end
      rst_n = 1'b1;
      #1;
      n_vec++;
      if (bus.req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rdy_release: got %b, required 0", bus.req_ready);
      end
      step();
      n_vec++;
      if (bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rdy_first_clk: got %b, required 1", bus.req_ready);
      end
   endtask

   task automatic check_result(input string nm, input int budget,
                               input logic [XLEN-1:0] d,
                               input logic [4:0] t, input logic e);
      int n;
      wait_res(budget, n);
      n_vec++;
      if (bus.res_data !== d || bus.res_tag !== t || bus.res_err !== e) begin
         n_err++;
         $display("FAIL %s: data=%h tag=%0d err=%b, required data=%h tag=%0d err=%b",
                  nm, bus.res_data, bus.res_tag, bus.res_err, d, t, e);
      end
      step();
   endtask

   task automatic test_left();
      send(32'h0000_00F0, 5'd4, 1'b1, 1'b0, 5'd5);
      check_result("shl4", 10, 32'h0000_0F00, 5'd5, 1'b0);
   endtask

   task automatic test_right();
      send(32'h8000_0000, 5'd31, 1'b0, 1'b1, 5'd12);
      check_result("sra31", 10, 32'hFFFF_FFFF, 5'd12, 1'b0);
      send(32'h8000_0000, 5'd31, 1'b0, 1'b0, 5'd13);
      check_result("srl31", 10, 32'h0000_0001, 5'd13, 1'b0);
   endtask

   task automatic test_latency();
      send(32'h1234_5678, 5'd0, 1'b0, 1'b0, 5'd9);
      n_vec++;
      if (bus.sh_start !== 1'b1 || bus.sh_data_in !== 32'h1234_5678 ||
          bus.sh_shift_amount !== 5'd0) begin
         n_err++;
         $display("FAIL lat_t1: start=%b in=%h amt=%0d, required 1 12345678 0",
                  bus.sh_start, bus.sh_data_in, bus.sh_shift_amount);
      end
      step();
      n_vec++;
      if (bus.sh_start !== 1'b0 || bus.res_valid !== 1'b0 ||
          bus.sh_data_in !== 32'h1234_5678 || bus.busy !== 1'b1) begin
         n_err++;
         $display("FAIL lat_t2: start=%b rv=%b in=%h busy=%b, required 0 0 12345678 1",
                  bus.sh_start, bus.res_valid, bus.sh_data_in, bus.busy);
      end
      step();
      n_vec++;
      if (bus.sh_start !== 1'b0 || bus.res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL lat_t3: start=%b rv=%b, required 0 0",
                  bus.sh_start, bus.res_valid);
      end
      step();
      n_vec++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h1234_5678 ||
          bus.res_tag !== 5'd9) begin
         n_err++;
         $display("FAIL lat_t4: rv=%b data=%h tag=%0d, required 1 12345678 9",
                  bus.res_valid, bus.res_data, bus.res_tag);
      end
      step();
   endtask

   task automatic test_back_to_back();
      int n;
      bus.res_ready = 1'b0;
      send(32'h0000_0001, 5'd3, 1'b1, 1'b0, 5'd3);
      wait_res(10, n);
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h8 ||
             bus.res_tag !== 5'd3 || bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold_%0d: rv=%b data=%h tag=%0d rdy=%b, required 1 8 3 0",
                     i, bus.res_valid, bus.res_data, bus.res_tag, bus.req_ready);
         end
         step();
      end
      bus.res_ready  = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_data   = 32'hF000_0000;
      bus.req_amount = 5'd4;
      bus.req_left   = 1'b0;
      bus.req_arith  = 1'b1;
      bus.req_tag    = 5'd7;
      #1;
      n_vec++;
      if (bus.req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL rdy_resp_done: got %b, required 0", bus.req_ready);
      end
      step();
      n_vec++;
      if (bus.res_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL b2b_idle: rv=%b rdy=%b, required 0 1",
                  bus.res_valid, bus.req_ready);
      end
      step();
      bus.req_valid = 1'b0;
      wait_res(10, n);
      n_vec++;
      if (n != 3) begin
         n_err++;
         $display("FAIL b2b_lat: res_valid after %0d cycles, required 3", n);
      end
      check_result("b2b_sra4", 1, 32'hFF00_0000, 5'd7, 1'b0);
   endtask

   task automatic test_flush_drain();
      lat = 5;
      send(32'h0000_0003, 5'd1, 1'b1, 1'b0, 5'd2);
      step();
      step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (bus.busy !== 1'b1 || bus.res_valid !== 1'b0 ||
             bus.req_ready !== 1'b0) begin
            n_err++;
            $display("FAIL drain_%0d: busy=%b rv=%b rdy=%b, required 1 0 0",
                     i, bus.busy, bus.res_valid, bus.req_ready);
         end
         step();
      end
      n_vec++;
      if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1 ||
          bus.res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL drain_exit: busy=%b rdy=%b rv=%b, required 0 1 0",
                  bus.busy, bus.req_ready, bus.res_valid);
      end
      lat = 2;
      send(32'h0000_0055, 5'd2, 1'b0, 1'b0, 5'd11);
      check_result("after_drain", 10, 32'h0000_0015, 5'd11, 1'b0);
   endtask

   task automatic test_flush_races();
      send(32'h0000_00AA, 5'd1, 1'b1, 1'b0, 5'd4);
      step();
      step();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      n_vec++;
      if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0) begin
         n_err++;
         $display("FAIL flush_done_same: busy=%b rv=%b, required 0 0",
                  bus.busy, bus.res_valid);
      end
      bus.res_ready = 1'b0;
      send(32'h0000_0001, 5'd1, 1'b1, 1'b0, 5'd6);
      check_result("pre_resp_flush", 10, 32'h0000_0002, 5'd6, 1'b0);
      n_vec++;
      if (bus.res_valid !== 1'b1) begin
         n_err++;
         $display("FAIL resp_hold: rv=%b, required 1", bus.res_valid);
      end
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      n_vec++;
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL flush_resp: rv=%b busy=%b, required 0 0",
                  bus.res_valid, bus.busy);
      end
      bus.res_ready = 1'b1;
      bus.flush     = 1'b1;
      bus.req_valid = 1'b1;
      #1;
      n_vec++;
      if (bus.req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL flush_idle_rdy: got %b, required 0", bus.req_ready);
      end
      step();
      bus.flush     = 1'b0;
      bus.req_valid = 1'b0;
      n_vec++;
      if (bus.busy !== 1'b0 || bus.sh_start !== 1'b0) begin
         n_err++;
         $display("FAIL flush_idle_acc: busy=%b start=%b, required 0 0",
                  bus.busy, bus.sh_start);
      end
   endtask

   task automatic test_reset_mid();
      send(32'h0000_0010, 5'd2, 1'b1, 1'b0, 5'd8);
      step();
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.busy !== 1'b0 || bus.res_valid !== 1'b0 ||
          bus.sh_data_in !== '0) begin
         n_err++;
         $display("FAIL mid_reset: busy=%b rv=%b in=%h, required 0 0 0",
                  bus.busy, bus.res_valid, bus.sh_data_in);
      end
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         n_vec++;
         if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_%0d: rv=%b busy=%b, required 0 0",
                     i, bus.res_valid, bus.busy);
         end
      end
      send(32'h0000_0010, 5'd2, 1'b1, 1'b0, 5'd8);
      check_result("post_reset_op", 10, 32'h0000_0040, 5'd8, 1'b0);
   endtask

`ifdef ALU_ISSUER_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      stall = 1'b1;
      bus.res_ready = 1'b0;
      send(32'h0000_1234, 5'd1, 1'b1, 1'b0, 5'd10);
      wait_res(100, n);
      n_vec++;
      if (n != 65) begin
         n_err++;
         $display("FAIL tmo_lat: res_valid %0d cycles after WAIT entry, required 64",
                  n - 1);
      end
      n_vec++;
      if (bus.res_err !== 1'b1 || bus.res_data !== '0 ||
          bus.res_tag !== 5'd10) begin
         n_err++;
         $display("FAIL tmo_res: err=%b data=%h tag=%0d, required 1 0 10",
                  bus.res_err, bus.res_data, bus.res_tag);
      end
      bus.res_ready = 1'b1;
      step();
      stall = 1'b0;
      send(32'h0000_0001, 5'd4, 1'b1, 1'b0, 5'd1);
      check_result("after_tmo", 10, 32'h0000_0010, 5'd1, 1'b0);
   endtask
`endif

   initial begin
      n_vec          = 0;
      n_err          = 0;
      lat            = 2;
      stall          = 1'b0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_data   = '0;
      bus.req_amount = '0;
      bus.req_left   = 1'b0;
      bus.req_arith  = 1'b0;
      bus.req_tag    = '0;
      bus.flush      = 1'b0;
      bus.res_ready  = 1'b1;
      test_reset();
      test_left();
      test_right();
      test_latency();
      test_back_to_back();
      test_flush_drain();
      test_flush_races();
      test_reset_mid();
`ifdef ALU_ISSUER_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/alu_shift_issuer.md
ALU_SHIFT_ISSUER -- requirements
Module: alu_shift_issuer

Interface
REQ-001 The block SHALL take XLEN from core_config_pkg, not from a local parameter.
REQ-002 TIMEOUT_CYCLES, 64, WAIT-state cycle limit (used only with ALU_ISSUER_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 req_valid/req_ready  in/out  1/1  upstream valid/ready handshake.
REQ-006 req_data  in  XLEN  operand; req_amount  in  $clog2(XLEN)  shift count.
REQ-007 req_left, req_arith  in  1/1  direction and arithmetic select; req_tag  in  5  destination register.
REQ-008 flush  in  1  pipeline flush; discard the in-flight operation.
REQ-009 sh_start  out  1; sh_data_in  out  XLEN; sh_shift_amount  out  $clog2(XLEN); sh_shift_left, sh_arithmetic  out  1/1.
REQ-010 sh_data_out  in  XLEN; sh_done  in  1  registered level from the shift unit.
REQ-011 res_valid/res_ready  out/in  1/1  result handshake; res_data  out  XLEN; res_tag  out  5; res_err  out  1.
REQ-012 busy  out  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL implement the states IDLE, ISSUE, WAIT, RESP and DRAIN, with a registered state.
REQ-014 IDLE: req_ready=1; on req_valid, register data/amount/left/arith/tag and go to ISSUE.
REQ-015 ISSUE: sh_start=1 for exactly one cycle, with sh_* operand outputs driven from the registered copies; go to WAIT.
REQ-016 sh_* operand outputs SHALL hold their registered values in every state other than IDLE; sh_start SHALL be 0 outside ISSUE.
REQ-017 sh_done SHALL be sampled only in WAIT; a stale high sh_done in IDLE or ISSUE SHALL be ignored.
REQ-018 WAIT: on sh_done=1, capture sh_data_out into res_data, set res_err=0 and go to RESP.
REQ-019 RESP: res_valid=1 with res_data, res_tag and res_err stable; on res_ready=1 go to IDLE.
REQ-020 While res_valid=1, the result outputs SHALL NOT change.
REQ-021 req_ready SHALL be 0 in all states except IDLE; no new request is accepted in the cycle that RESP completes.
REQ-022 On flush in ISSUE or WAIT, go to DRAIN; DRAIN waits for sh_done, discards the result, then returns to IDLE.
REQ-023 On flush in RESP, drop res_valid next cycle and go to IDLE.
REQ-024 On flush in IDLE, a simultaneous req_valid SHALL NOT be accepted.
REQ-025 If flush and sh_done occur in the same WAIT cycle, flush wins: go to IDLE with no result.
REQ-026 Latency: request accepted at cycle T gives sh_start at T+1 and res_valid at one cycle after sh_done is seen; with amount 0, res_valid rises at T+4.

Reset
REQ-027 While rst_n=0, state SHALL be IDLE and the following SHALL be 0: sh_start, sh_* operands, res_valid, res_data, res_tag, res_err and busy.
REQ-028 req_ready SHALL be 0 during reset and 1 from the first clock after reset is released.
REQ-029 Reset asserted mid-operation SHALL abandon the operation with no result emitted.

Configuration
REQ-030 With ALU_ISSUER_TIMEOUT_EN defined, a counter clears on WAIT entry and increments each cycle in WAIT or DRAIN.
REQ-031 With the macro defined and the counter reaching TIMEOUT_CYCLES, WAIT goes to RESP with res_err=1 and res_data=0, and DRAIN goes to IDLE.
REQ-032 Without ALU_ISSUER_TIMEOUT_EN, no counter exists, res_err is tied 0, and WAIT/DRAIN wait indefinitely.

Verification
REQ-033 Send data 0x000000F0, amount 4, left, res_ready=1 -> res_data 0x00000F00, tag echoed, res_err 0.
REQ-034 Send data 0x80000000, amount 31, right arithmetic -> res_data 0xFFFFFFFF; logical right -> 0x00000001.
REQ-035 Send amount 0, accepted at T -> sh_start pulses only at T+1; res_valid at T+4; res_data equals req_data.
REQ-036 Hold res_ready=0 for 10 cycles -> res_valid and res_data stable, req_ready 0 throughout; a back-to-back second request ignores stale sh_done and returns the correct second result.
REQ-037 Flush 2 cycles after sh_start -> no res_valid, busy stays high until sh_done, then req_ready=1; the next operation is correct.
REQ-038 With the macro defined and sh_done forced 0 -> res_valid with res_err=1 and res_data 0 exactly TIMEOUT_CYCLES cycles after WAIT entry.
